kbd_fifo: RTL and testbench
===========================

KBD_FIFO -- requirements
Module: kbd_fifo

Interface
REQ-001 The module SHALL be parameterised, one per line: name, default, meaning.
  DEPTH_LOG2  4  log2 of FIFO depth (16 entries).
REQ-002 The module SHALL have these ports, one per line: name  direction  width  meaning.
  clock     in   1   system clock, 25 MHz domain shared with ps2 and pctl
  reset     in   1   synchronous, active-high reset
  ps2_hit   in   1   one-cycle strobe: new scancode on ps2_data
  ps2_data  in   8   scancode from PS/2 receiver
  rd        in   1   one-cycle pop strobe (pctl read of port 60h)
  clr       in   1   one-cycle flush strobe
  data      out  8   head-of-FIFO scancode
  count     out  DEPTH_LOG2+1  entries held, 0..16
  empty     out  1   count == 0
  full      out  1   count == 16
  overflow  out  1   sticky: a scancode was dropped
  irq_req   out  1   IRQ1 request level to interrupt controller
  irq_ack   in   1   one-cycle acknowledge of irq_req
REQ-003 The block SHALL use one clock and a synchronous, active-high reset named reset; every register SHALL update only on the rising edge of clock.

Function
REQ-004 Storage SHALL be a 2^DEPTH_LOG2 x 8 circular buffer with write and read pointers of DEPTH_LOG2 bits wrapping modulo depth.
REQ-005 ps2_hit with full=0 SHALL store ps2_data at the write pointer, advance it and increment count on the same edge.
REQ-006 ps2_hit with full=1 SHALL drop the byte, leave pointers/count unchanged and set overflow=1.
REQ-007 rd with empty=0 SHALL advance the read pointer and decrement count; rd with empty=1 SHALL have no effect.
REQ-008 Simultaneous ps2_hit and rd with 0<count<16 SHALL perform both; count unchanged.
REQ-009 Simultaneous ps2_hit and rd at count=16 SHALL perform both (pop frees the slot); count stays 16, overflow unchanged.
REQ-010 Simultaneous ps2_hit and rd at count=0 SHALL perform only the push; count becomes 1.
REQ-011 data SHALL be combinational: buffer entry at read pointer when empty=0, 8'h00 when empty=1.
REQ-012 empty and full SHALL be derived from count and change in the same cycle as count.
REQ-013 clr SHALL zero both pointers, count and overflow, and force the IRQ FSM to IDLE; clr SHALL take priority over ps2_hit and rd in the same cycle (both ignored).
REQ-014 IRQ FSM states: IDLE, REQ, SERV; irq_req SHALL be a registered output, 1 only in REQ.
REQ-015 IDLE -> REQ when empty=0; otherwise stay.
REQ-016 REQ -> SERV on irq_ack; irq_ack in IDLE or SERV SHALL be ignored.
REQ-017 SERV -> IDLE on rd; one request is raised per scancode consumed.
REQ-018 irq_req SHALL rise exactly one clock after empty falls and fall on the edge sampling irq_ack.
REQ-019 While the FIFO empties to 0 during REQ via rd without ack, FSM SHALL return to IDLE and drop irq_req on the next edge.

Reset
REQ-020 On reset: pointers=0, count=0, empty=1, full=0, overflow=0, data=8'h00, irq_req=0, FSM=IDLE; reset SHALL override clr, ps2_hit, rd and irq_ack.
REQ-021 Buffer contents SHALL NOT require reset; reset mid-operation SHALL discard all held bytes.

Verification
REQ-022 Push 8'h1C at edge k -> empty=0 and data=8'h1C after k; irq_req=1 after k+1; irq_ack -> irq_req=0; rd -> count=0, data=8'h00, FSM IDLE.
REQ-023 Push 17 bytes 8'h01..8'h11 without reads -> full=1, count=16, overflow=1; 16 pops return 8'h01..8'h10 in order, 8'h11 absent.
REQ-024 At count=16 assert ps2_hit=8'hAA with rd same cycle -> count=16, overflow=0; after 15 further pops data=8'hAA.
REQ-025 Wrap: 10 pushes, 10 pops, 10 pushes 8'h50..8'h59 -> pops return 8'h50..8'h59, count ends 0.
REQ-026 With count=3 and irq_req=1 assert clr and ps2_hit together -> next cycle count=0, irq_req=0, overflow=0, data=8'h00.
REQ-027 Assert reset during SERV with count=5 -> next cycle all outputs at REQ-020 values; no irq_req until a new push.

Source files
------------

// File: rtl/kbd_fifo.sv
// Keyboard scancode FIFO: 16-entry circular buffer between the PS/2
// receiver and the port-60h read path, with a sticky overflow flag and a
// small IRQ1 request/acknowledge handshake (one request per scancode).
module kbd_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ps2_hit,
    input  logic [7:0]            ps2_data,
    input  logic                  rd,
    input  logic                  clr,
    output logic [7:0]            data,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  empty,
    output logic                  full,
    output logic                  overflow,
    output logic                  irq_req,
    input  logic                  irq_ack
);

    localparam logic [DEPTH_LOG2:0] DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_SERV = 2'd2;

    logic [7:0]              mem [0:(1<<DEPTH_LOG2)-1];
    logic [DEPTH_LOG2-1:0]   wptr_q, wptr_d;
    logic [DEPTH_LOG2-1:0]   rptr_q, rptr_d;
    logic [DEPTH_LOG2:0]     count_q, count_d;
    logic                    ovf_q, ovf_d;
    logic [1:0]              st_q, st_d;
    logic                    irq_req_q, irq_req_d;
    logic                    do_push, do_pop;

    assign count    = count_q;
    assign empty    = (count_q == '0);
    assign full     = (count_q == DEPTH);
    assign overflow = ovf_q;
    assign irq_req  = irq_req_q;
    assign data     = empty ? 8'h00 : mem[rptr_q];

    // A push at full is allowed only when a pop frees the head slot this cycle.
    always_comb begin
        do_pop  = rd && !empty && !clr;
        do_push = ps2_hit && (!full || do_pop) && !clr;
    end

    // Pointer, count and overflow next-state.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (clr) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end else begin
            if (do_push) wptr_d = wptr_q + 1'b1;
            if (do_pop)  rptr_d = rptr_q + 1'b1;
            if (do_push && !do_pop)      count_d = count_q + 1'b1;
            else if (do_pop && !do_push) count_d = count_q - 1'b1;
            if (ps2_hit && !do_push)     ovf_d   = 1'b1;
        end
    end

    // IRQ handshake: raise while data waits, hold until ack, rearm on the read.
    always_comb begin
        st_d = st_q;
        if (clr) begin
            st_d = ST_IDLE;
        end else begin
            case (st_q)
                ST_IDLE: if (!empty) st_d = ST_REQ;
                ST_REQ:  if (irq_ack) st_d = ST_SERV;
                         else if (empty) st_d = ST_IDLE;
                ST_SERV: if (rd) st_d = ST_IDLE;
                default: st_d = ST_IDLE;
            endcase
        end
        irq_req_d = (st_d == ST_REQ);
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            st_q      <= ST_IDLE;
            irq_req_q <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            st_q      <= st_d;
            irq_req_q <= irq_req_d;
        end
    end

    // Storage array, no reset needed: count gates visibility of stale bytes.
    always_ff @(posedge clock) begin
        if (do_push && !reset) mem[wptr_q] <= ps2_data;
    end

endmodule

// File: tb/tb_kbd_fifo.sv
// Self-checking bench for kbd_fifo: queue-based reference model compared
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_kbd_fifo;

    logic       clock = 1'b0;
    logic       reset, ps2_hit, rd, clr, irq_ack;
    logic [7:0] ps2_data;
    logic [7:0] data;
    logic [4:0] count;
    logic       empty, full, overflow, irq_req;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // reference model
    logic [7:0] mq[$];
    bit         m_ovf;
    int         m_irq;     // 0 idle, 1 requesting, 2 being serviced
    int         m_n;

    kbd_fifo #(.DEPTH_LOG2(4)) dut (
        .clock(clock), .reset(reset), .ps2_hit(ps2_hit), .ps2_data(ps2_data),
        .rd(rd), .clr(clr), .data(data), .count(count), .empty(empty),
        .full(full), .overflow(overflow), .irq_req(irq_req), .irq_ack(irq_ack)
    );

    always #20 clock = ~clock;

    // Model advances on every rising edge from the inputs held across it.
    always @(posedge clock) begin
        m_n = mq.size();
        if (reset || clr) begin
            mq.delete();
            m_ovf = 1'b0;
            m_irq = 0;
        end else begin
            case (m_irq)
                0: if (m_n != 0) m_irq = 1;
                1: if (irq_ack) m_irq = 2; else if (m_n == 0) m_irq = 0;
                default: if (rd) m_irq = 0;
            endcase
            if (rd && m_n > 0) void'(mq.pop_front());
            if (ps2_hit) begin
                if (mq.size() < 16) mq.push_back(ps2_data);
                else m_ovf = 1'b1;
            end
        end
    end

    task automatic cmp(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous comparison against the model on the falling edge.
    always @(negedge clock) begin
        if (chk_en) begin
            cmp("m_count", int'(count), mq.size());
            cmp("m_data", int'(data), mq.size() > 0 ? int'(mq[0]) : 0);
            cmp("m_empty", int'(empty), int'(mq.size() == 0));
            cmp("m_full", int'(full), int'(mq.size() == 16));
            cmp("m_ovf", int'(overflow), int'(m_ovf));
            cmp("m_irq", int'(irq_req), int'(m_irq == 1));
        end
    end

    task automatic idle();
        reset = 0; ps2_hit = 0; rd = 0; clr = 0; irq_ack = 0; ps2_data = 8'h00;
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    task automatic push(input logic [7:0] b);
        idle(); ps2_hit = 1; ps2_data = b; step(); idle();
    endtask

    task automatic pop();
        idle(); rd = 1; step(); idle();
    endtask

    task automatic flush();
        idle(); clr = 1; step(); idle();
    endtask

    initial begin
        idle();
        m_ovf = 0; m_irq = 0;
        @(negedge clock);
        reset = 1; step(); reset = 0;
        chk_en = 1'b1;
        cmp("rst_count", int'(count), 0);
        cmp("rst_empty", int'(empty), 1);
        cmp("rst_full", int'(full), 0);
        cmp("rst_data", int'(data), 8'h00);
        cmp("rst_irq", int'(irq_req), 0);

        // single scancode with full IRQ handshake
        push(8'h1C);
        cmp("one_empty", int'(empty), 0);
        cmp("one_data", int'(data), 8'h1C);
        cmp("one_irq_early", int'(irq_req), 0);
        step();
        cmp("one_irq", int'(irq_req), 1);
        irq_ack = 1; step(); idle();
        cmp("one_ack", int'(irq_req), 0);
        pop();
        cmp("one_cnt", int'(count), 0);
        cmp("one_data0", int'(data), 8'h00);
        step(); step();
        cmp("one_idle", int'(irq_req), 0);

        // overflow: 17 pushes, 16 pops
        for (int i = 1; i <= 17; i++) push(8'(i));
        cmp("ovf_full", int'(full), 1);
        cmp("ovf_count", int'(count), 16);
        cmp("ovf_flag", int'(overflow), 1);
        for (int i = 1; i <= 16; i++) begin
            cmp("ovf_order", int'(data), i);
            pop();
        end
        cmp("ovf_drained", int'(empty), 1);

        // push+pop at full
        flush();
        for (int i = 0; i < 16; i++) push(8'(8'h20 + i));
        ps2_hit = 1; ps2_data = 8'hAA; rd = 1; step(); idle();
        cmp("fp_count", int'(count), 16);
        cmp("fp_ovf", int'(overflow), 0);
        cmp("fp_head", int'(data), 8'h21);
        for (int i = 0; i < 15; i++) pop();
        cmp("fp_tail", int'(data), 8'hAA);

        // pointer wrap
        flush();
        for (int i = 0; i < 10; i++) push(8'(8'h90 + i));
        for (int i = 0; i < 10; i++) pop();
        for (int i = 0; i < 10; i++) push(8'(8'h50 + i));
        for (int i = 0; i < 10; i++) begin
            cmp("wrap_order", int'(data), 8'h50 + i);
            pop();
        end
        cmp("wrap_count", int'(count), 0);

        // push+pop at empty performs only the push
        ps2_hit = 1; ps2_data = 8'h3E; rd = 1; step(); idle();
        cmp("ep_count", int'(count), 1);
        cmp("ep_data", int'(data), 8'h3E);

        // clear beats a simultaneous push
        flush();
        for (int i = 0; i < 3; i++) push(8'(8'h60 + i));
        step();
        cmp("clr_pre_irq", int'(irq_req), 1);
        clr = 1; ps2_hit = 1; ps2_data = 8'h77; step(); idle();
        cmp("clr_count", int'(count), 0);
        cmp("clr_irq", int'(irq_req), 0);
        cmp("clr_ovf", int'(overflow), 0);
        cmp("clr_data", int'(data), 8'h00);

        // reset while being serviced
        for (int i = 0; i < 5; i++) push(8'(8'h70 + i));
        step();
        irq_ack = 1; step(); idle();
        cmp("serv_irq", int'(irq_req), 0);
        reset = 1; step(); idle();
        cmp("srst_count", int'(count), 0);
        cmp("srst_empty", int'(empty), 1);
        cmp("srst_data", int'(data), 8'h00);
        step(); step(); step();
        cmp("srst_noirq", int'(irq_req), 0);
        push(8'h12); step();
        cmp("srst_newirq", int'(irq_req), 1);

        // randomized traffic in fill/drain phases
        for (int c = 0; c < 3000; c++) begin
            int ph;
            ph = (c / 150) % 2;
            idle();
            ps2_hit  = ($urandom_range(99) < (ph ? 75 : 30));
            rd       = ($urandom_range(99) < (ph ? 25 : 65));
            ps2_data = 8'($urandom);
            irq_ack  = ($urandom_range(99) < 30);
            clr      = ($urandom_range(99) < 2);
            reset    = ($urandom_range(499) < 1);
            step();
        end
        idle(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
